// File: rtl/ex_matrix_unit_pkg.sv
// Shared ALU control code, FSM encoding and element helper for the EX-stage
// 2x2 signed 8-bit matrix multiply unit.
package ex_matrix_unit_pkg;

  localparam logic [3:0] ALU_MATRIX_MUL = 4'b1010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } mat_state_e;

  // Element idx = 2*row + col; (0,0) lives in bits 7:0, (1,1) in bits 31:24.
  function automatic logic [7:0] mat_elem(input logic [31:0] m, input logic [1:0] idx);
    return m[{idx, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/ex_matrix_unit_mac8.sv
// Signed 8x8 multiply feeding a 17-bit accumulator; shared by all MAC steps.
// sum_lo is the low byte of the accumulator plus this cycle's product.
module mac8 (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] sum_lo
);

  logic signed [15:0] prod;
  logic signed [16:0] sum;
  logic signed [16:0] acc_d;
  logic signed [16:0] acc_q;

  assign prod   = $signed(a) * $signed(b);
  assign sum    = acc_q + {prod[15], prod};
  assign sum_lo = sum[7:0];

  // clr wins over en so the final step of an element can consume sum and
  // leave a clean accumulator for the next element in the same cycle.
  always_comb begin
    acc_d = acc_q;
    if (clr) begin
      acc_d = '0;
    end else if (en) begin
      acc_d = sum;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/ex_matrix_unit.sv
// Multi-cycle EX unit computing C = A x B on packed 2x2 signed 8-bit matrices,
// one MAC per cycle, stalling the pipeline until the product is ready.
module ex_matrix_unit
  import ex_matrix_unit_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ELEM_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  input  logic [3:0]        alu_ctrl,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  input  logic              pipe_stall,
  input  logic              flush,
  output logic              stall_req,
  output logic              busy,
  output logic              result_valid,
  output logic [DATA_W-1:0] result
);

  // Handshake: the unit accepts when hit is seen in IDLE and holds stall_req
  // until the product is complete; result is only meaningful while
  // result_valid is high, and DONE is left on the first cycle with !pipe_stall.

  mat_state_e        state_q, state_d;
  logic [1:0]        e_q, e_d;
  logic              k_q, k_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [DATA_W-1:0] result_q, result_d;

  logic              hit;
  logic              mac_clr;
  logic              mac_en;
  logic [ELEM_W-1:0] mac_a;
  logic [ELEM_W-1:0] mac_b;
  logic [ELEM_W-1:0] mac_sum_lo;

  assign hit = ex_valid && (alu_ctrl == ALU_MATRIX_MUL) && !flush;

  // Step (e,k) multiplies A[r][k] by B[k][c] with r=e[1], c=e[0].
  assign mac_a = mat_elem(a_q, {e_q[1], k_q});
  assign mac_b = mat_elem(b_q, {k_q, e_q[0]});

  mac8 u_mac8 (
    .clk    (clk),
    .rst    (rst),
    .clr    (mac_clr),
    .en     (mac_en),
    .a      (mac_a),
    .b      (mac_b),
    .sum_lo (mac_sum_lo)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      e_q      <= '0;
      k_q      <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      e_q      <= e_d;
      k_q      <= k_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (hit) state_d = ST_CALC;
        ST_CALC: if (k_q && (e_q == 2'd3)) state_d = ST_DONE;
        ST_DONE: if (!pipe_stall) state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Counters, operand latches and element write-back.
  always_comb begin
    e_d      = e_q;
    k_d      = k_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    mac_clr  = 1'b0;
    mac_en   = 1'b0;
    if (flush) begin
      mac_clr = 1'b1;
      e_d     = '0;
      k_d     = 1'b0;
    end else if ((state_q == ST_IDLE) && hit) begin
      a_d     = op_a;
      b_d     = op_b;
      e_d     = '0;
      k_d     = 1'b0;
      mac_clr = 1'b1;
    end else if (state_q == ST_CALC) begin
      mac_en = 1'b1;
      if (k_q) begin
        result_d[{e_q, 3'b000} +: ELEM_W] = mac_sum_lo;
        mac_clr = 1'b1;
        k_d     = 1'b0;
        e_d     = e_q + 2'd1;
      end else begin
        k_d = 1'b1;
      end
    end
  end

  always_comb begin
    busy         = (state_q == ST_CALC);
    result_valid = (state_q == ST_DONE) && !flush;
    stall_req    = !rst && (((state_q == ST_IDLE) && hit) || (state_q == ST_CALC));
    result       = result_q;
  end

endmodule

// File: tb/tb_ex_matrix_unit.sv
// Bench for ex_matrix_unit: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a schedule/arithmetic model.
module tb_ex_matrix_unit;
  import ex_matrix_unit_pkg::*;

  localparam logic [3:0] ALU_ADD = 4'b0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid;
  logic [3:0]  alu_ctrl;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        pipe_stall;
  logic        flush;
  logic        stall_req;
  logic        busy;
  logic        result_valid;
  logic [31:0] result;

  int n_vec  = 0;
  int n_fail = 0;

  ex_matrix_unit #(.DATA_W(32), .ELEM_W(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .ex_valid     (ex_valid),
    .alu_ctrl     (alu_ctrl),
    .op_a         (op_a),
    .op_b         (op_b),
    .pipe_stall   (pipe_stall),
    .flush        (flush),
    .stall_req    (stall_req),
    .busy         (busy),
    .result_valid (result_valid),
    .result       (result)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- reference arithmetic ----------------
  function automatic int sel(input logic [31:0] m, input int r, input int c);
    logic [7:0] v;
    v = m[8*(2*r+c) +: 8];
    return int'($signed(v));
  endfunction

  function automatic logic [31:0] matmul(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] res;
    int s;
    res = '0;
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < 2; c++) begin
        s = sel(a, r, 0) * sel(b, 0, c) + sel(a, r, 1) * sel(b, 1, c);
        res[8*(2*r+c) +: 8] = s[7:0];
      end
    end
    return res;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard model ----------------
  // cnt: 0 idle, 1..8 = cycles into the computation, 9 = result presented.
  logic [31:0] exp_q[$];
  int          cnt       = 0;
  bit          zero_flag = 1'b1;

  always @(posedge clk) begin
    bit m_hit;
    m_hit = ex_valid && (alu_ctrl == ALU_MATRIX_MUL) && !flush;
    if (rst) begin
      cnt = 0;
      exp_q.delete();
      zero_flag = 1'b1;
    end else if (flush) begin
      cnt = 0;
      exp_q.delete();
    end else if (cnt == 0) begin
      if (m_hit) begin
        exp_q.push_back(matmul(op_a, op_b));
        cnt = 1;
        zero_flag = 1'b0;
      end
    end else if (cnt < 9) begin
      cnt++;
    end else if (!pipe_stall) begin
      cnt = 0;
      exp_q.delete();
    end
  end

  always @(negedge clk) begin
    bit m_hit, e_busy, e_rv, e_st;
    if (rst) begin
      chk("rst stall_req", {31'd0, stall_req}, 32'd0);
      chk("rst busy", {31'd0, busy}, 32'd0);
      chk("rst result_valid", {31'd0, result_valid}, 32'd0);
      chk("rst result", result, 32'd0);
    end else begin
      m_hit  = ex_valid && (alu_ctrl == ALU_MATRIX_MUL) && !flush;
      e_busy = (cnt >= 1) && (cnt <= 8);
      e_rv   = (cnt == 9) && !flush;
      e_st   = ((cnt == 0) && m_hit) || e_busy;
      chk("stall_req", {31'd0, stall_req}, {31'd0, e_st});
      chk("busy", {31'd0, busy}, {31'd0, e_busy});
      chk("result_valid", {31'd0, result_valid}, {31'd0, e_rv});
      if (e_rv) begin
        if (exp_q.size() == 0) chk("scoreboard empty", result, ~result);
        else                   chk("result", result, exp_q[0]);
      end
      if (zero_flag) chk("result after reset", result, 32'd0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ex_valid   = 1'b0;
    alu_ctrl   = ALU_ADD;
    op_a       = '0;
    op_b       = '0;
    pipe_stall = 1'b0;
    flush      = 1'b0;
  endtask

  // Presents one MATRIX_MUL for a cycle and checks result, latency and stall
  // length; returns one cycle after DONE so the unit is idle again.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] lit, input string name);
    int stalls;
    int lat;
    bit got;
    ex_valid = 1'b1;
    alu_ctrl = ALU_MATRIX_MUL;
    op_a     = a;
    op_b     = b;
    stalls   = 0;
    lat      = 0;
    got      = 1'b0;
    @(negedge clk);
    if (stall_req) stalls++;
    next_cycle();
    ex_valid = 1'b0;
    alu_ctrl = ALU_ADD;
    for (int i = 1; i <= 20 && !got; i++) begin
      @(negedge clk);
      if (stall_req) stalls++;
      if (result_valid) begin
        got = 1'b1;
        lat = i;
        chk({name, " result"}, result, lit);
      end else begin
        next_cycle();
      end
    end
    chk({name, " latency"}, lat, 32'd9);
    chk({name, " stall cycles"}, stalls, 32'd9);
    next_cycle();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int rvcnt;
    int stcnt;
    bit got;
    logic [31:0] pool [4];
    pool[0] = 32'h80808080;
    pool[1] = 32'h7F7F7F7F;
    pool[2] = 32'h807F7F80;
    pool[3] = 32'hFFFFFFFF;

    rst = 1'b1;
    idle_inputs();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("reset stall_req", {31'd0, stall_req}, 32'd0);
    chk("reset result", result, 32'd0);
    next_cycle();

    // model pinned to hand-computed products
    chk("model basic", matmul(32'h04030201, 32'h04030201), 32'h160F0A07);
    chk("model wrap", matmul(32'h7F7F7F7F, 32'h7F7F7F7F), 32'h02020202);

    do_op(32'h04030201, 32'h04030201, 32'h160F0A07, "basic");
    do_op(32'h01000001, 32'h04030201, 32'h04030201, "identity");
    do_op(32'hFF0000FF, 32'h04030201, 32'hFCFDFEFF, "negation");
    do_op(32'h7F7F7F7F, 32'h7F7F7F7F, 32'h02020202, "wrap");

    // flush in the middle of CALC, then a fresh op two cycles later
    ex_valid = 1'b1; alu_ctrl = ALU_MATRIX_MUL;
    op_a = 32'h11223344; op_b = 32'h55667788;
    next_cycle();
    ex_valid = 1'b0; alu_ctrl = ALU_ADD;
    next_cycle();
    next_cycle();
    next_cycle();
    flush = 1'b1;
    next_cycle();
    flush = 1'b0;
    @(negedge clk);
    chk("flush busy", {31'd0, busy}, 32'd0);
    chk("flush stall_req", {31'd0, stall_req}, 32'd0);
    chk("flush result_valid", {31'd0, result_valid}, 32'd0);
    next_cycle();
    do_op(32'h04030201, 32'h01000001, 32'h04030201, "after flush");

    // flush coinciding with a would-be accept
    ex_valid = 1'b1; alu_ctrl = ALU_MATRIX_MUL; flush = 1'b1;
    @(negedge clk);
    chk("flush on accept stall_req", {31'd0, stall_req}, 32'd0);
    next_cycle();
    idle_inputs();
    @(negedge clk);
    chk("flush on accept busy", {31'd0, busy}, 32'd0);
    next_cycle();

    // pipe_stall holds DONE for 3 extra cycles with the op still in EX
    ex_valid = 1'b1; alu_ctrl = ALU_MATRIX_MUL; pipe_stall = 1'b1;
    op_a = 32'h04030201; op_b = 32'h04030201;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (result_valid) got = 1'b1;
      else next_cycle();
    end
    rvcnt = 1;
    stcnt = stall_req ? 1 : 0;
    for (int i = 0; i < 2; i++) begin
      next_cycle();
      @(negedge clk);
      if (result_valid) rvcnt++;
      if (stall_req) stcnt++;
    end
    next_cycle();
    pipe_stall = 1'b0;
    @(negedge clk);
    if (result_valid) rvcnt++;
    if (stall_req) stcnt++;
    chk("pipe_stall valid cycles", rvcnt, 32'd4);
    chk("pipe_stall done stalls", stcnt, 32'd0);
    chk("pipe_stall result", result, 32'h160F0A07);
    next_cycle();
    alu_ctrl = ALU_ADD;
    stcnt = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (stall_req || busy || result_valid) stcnt++;
      next_cycle();
    end
    chk("add after done", stcnt, 32'd0);
    idle_inputs();

    // asynchronous reset mid-CALC
    ex_valid = 1'b1; alu_ctrl = ALU_MATRIX_MUL;
    op_a = 32'h7F7F7F7F; op_b = 32'h01010101;
    next_cycle();
    idle_inputs();
    next_cycle();
    next_cycle();
    rst = 1'b1;
    #1;
    chk("async rst busy", {31'd0, busy}, 32'd0);
    chk("async rst stall_req", {31'd0, stall_req}, 32'd0);
    chk("async rst result", result, 32'd0);
    next_cycle();
    rst = 1'b0;
    next_cycle();
    do_op(32'h00000000, 32'h04030201, 32'h00000000, "after reset zero");
    do_op(32'h04030201, 32'hFF0000FF, 32'hFCFDFEFF, "after reset");

    // randomized traffic; the per-cycle monitor does the checking
    for (int cyc = 0; cyc < 1500; cyc++) begin
      rst        = ($urandom_range(0, 199) == 0);
      ex_valid   = ($urandom_range(0, 3) != 0);
      alu_ctrl   = ($urandom_range(0, 2) != 0) ? ALU_MATRIX_MUL : 4'($urandom_range(0, 15));
      pipe_stall = ($urandom_range(0, 2) == 0);
      flush      = ($urandom_range(0, 29) == 0);
      op_a       = ($urandom_range(0, 4) == 0) ? pool[$urandom_range(0, 3)] : $urandom;
      op_b       = ($urandom_range(0, 4) == 0) ? pool[$urandom_range(0, 3)] : $urandom;
      next_cycle();
    end
    rst = 1'b0;
    idle_inputs();
    repeat (12) next_cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
